sdram_wb_bridge: RTL and testbench
==================================

# sdram_wb_bridge

Registered Wishbone B3 classic slave that converts bus cycles into single-word requests for the SDRAM driver. Data and address widths are parametrised. The bridge has explicit request/wait/response sequencing, latched request fields and captured read data. It also forwards driver errors and handles a master abort without corrupting the next transfer. It sits between the system Wishbone interconnect and the SDRAM driver command port.

## Interface
- ADDR_W, 32, width of the Wishbone and SDRAM address.
- DATA_W, 16, width of the data words.
- TIMEOUT, 255, maximum number of WAIT cycles before `wbs_err` is raised (only when the timeout is compiled in; valid range 1..65535).

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wbs_address  in  ADDR_W  word address.
- wbs_writedata  in  DATA_W  write data.
- wbs_readdata  out  DATA_W  read data; registered.
- wbs_strobe  in  1  Wishbone STB.
- wbs_cycle  in  1  Wishbone CYC.
- wbs_write  in  1  1 = write, 0 = read.
- wbs_ack  out  1  transfer done; one-cycle pulse.
- wbs_err  out  1  transfer failed; one-cycle pulse, mutually exclusive with `wbs_ack`.
- sdram_addr  out  ADDR_W  latched request address.
- sdram_wr  out  1  write request; one-cycle pulse.
- sdram_rd  out  1  read request; one-cycle pulse.
- sdram_wr_data  out  DATA_W  latched write data.
- sdram_rd_data  in  DATA_W  read data; valid with `sdram_op_done`.
- sdram_op_done  in  1  driver completion pulse.
- sdram_op_err  in  1  driver error pulse; takes priority over `sdram_op_done` when both are high.

## Operation
- Reset values: all outputs 0, state IDLE, timeout counter 0, `wbs_readdata` register 0.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE
  - When `wbs_cycle & wbs_strobe` is high, latch address, write data and `wbs_write`, then go to REQ.
  - `sdram_op_done` and `sdram_op_err` are ignored in IDLE.
- REQ
  - Drive `sdram_rd` or `sdram_wr` high for exactly this cycle, then go to WAIT.
  - A completion arriving in REQ is treated exactly as it would be in WAIT.
- WAIT
  - `sdram_op_err`: set the error flag and go to RESP.
  - `sdram_op_done`: on a read, capture `sdram_rd_data` into the `wbs_readdata` register; go to RESP.
  - `wbs_cycle` low (master abort): go to DRAIN.
- RESP: pulse `wbs_ack`, or `wbs_err` if the error flag is set, for one cycle; clear the flag; go to IDLE.
- DRAIN
  - The SDRAM operation cannot be cancelled, so the bridge waits for `sdram_op_done` or `sdram_op_err` and then returns to IDLE.
  - No ack or err is issued, and read data is not captured.
- A new strobe in the cycle after the ack is a new transfer, so no strobe-deassert gap is needed between back-to-back transfers. A strobe held high across IDLE starts a new request.
- `sdram_addr` and `sdram_wr_data` stay stable from REQ until the next IDLE latch.
- `wbs_readdata` holds its value until the next read completion.

## Timing
- Request latency: strobe sampled in IDLE at edge N; `sdram_rd`/`sdram_wr` high in cycle N+1.
- Response latency: completion sampled at edge M; `wbs_ack`/`wbs_err` high in cycle M+1; next request accepted at edge M+2.
- Minimum transfer: 3 cycles from strobe to ack when the driver completes in the REQ cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. A driver completion that follows is ignored in IDLE.

## Configuration
- `SDRAM_WB_TIMEOUT_EN` defined
  - The WAIT counter increments every WAIT cycle.
  - When the counter reaches TIMEOUT with no completion, the bridge pulses `wbs_err` the next cycle and returns to IDLE.
  - The counter clears on leaving WAIT.
  - DRAIN is also bounded by TIMEOUT and exits silently to IDLE.
- Undefined: no counter is built, and WAIT and DRAIN last until the driver completes.

## Test plan
- Read at address 0x0000_0100, driver returns 0xBEEF 4 cycles after `sdram_rd` -> single `sdram_rd` pulse with `sdram_addr`=0x100; `wbs_ack` one cycle after done; `wbs_readdata`=0xBEEF.
- Write 0x1234 to 0x20, then a back-to-back read of 0x21 with strobe held high -> exactly two request pulses (wr then rd); `sdram_wr_data`=0x1234; two acks; no duplicate request.
- `sdram_op_err` and `sdram_op_done` asserted together -> `wbs_err` pulse, no `wbs_ack`, `wbs_readdata` unchanged.
- Master drops `wbs_cycle` 2 cycles after `sdram_rd`; done arrives 3 cycles later -> no ack/err; the next transfer completes normally with its own data.
- `SDRAM_WB_TIMEOUT_EN`, TIMEOUT=8, driver silent -> `wbs_err` pulses 9 cycles after the request pulse, and the bridge accepts a new strobe afterwards.
- Reset asserted while in WAIT -> all outputs 0 immediately; the late `sdram_op_done` produces no ack.

Source files
------------

// File: rtl/sdram_wb_bridge.sv
// Wishbone B3 classic slave -> single-word SDRAM driver requests.
// Optional WAIT/DRAIN watchdog is compiled in with `define SDRAM_WB_TIMEOUT_EN.
module sdram_wb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wbs_address,
  input  logic [DATA_W-1:0] wbs_writedata,
  output logic [DATA_W-1:0] wbs_readdata,
  input  logic              wbs_strobe,
  input  logic              wbs_cycle,
  input  logic              wbs_write,
  output logic              wbs_ack,
  output logic              wbs_err,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_wr,
  output logic              sdram_rd,
  output logic [DATA_W-1:0] sdram_wr_data,
  input  logic [DATA_W-1:0] sdram_rd_data,
  input  logic              sdram_op_done,
  input  logic              sdram_op_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                tmo;

`ifdef SDRAM_WB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  // Fires in the last allowed WAIT/DRAIN cycle so the error lands right after it.
  assign tmo = (state_q == WAIT || state_q == DRAIN) && (cnt_q == 16'(TIMEOUT - 1));
  assign cnt_d = ((state_q == WAIT || state_q == DRAIN) && state_d == state_q) ? cnt_q + 16'd1 : 16'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (wbs_cycle && wbs_strobe) begin
        addr_d  = wbs_address;
        wdata_d = wbs_writedata;
        we_d    = wbs_write;
        state_d = REQ;
      end
      // Completions in REQ are handled identically to WAIT.
      REQ, WAIT: begin
        if (sdram_op_err) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (sdram_op_done) begin
          if (!we_q) rdata_d = sdram_rd_data;
          state_d = RESP;
        end else if (!wbs_cycle) begin
          state_d = DRAIN;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      DRAIN: if (sdram_op_done || sdram_op_err || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign sdram_addr    = addr_q;
  assign sdram_wr_data = wdata_q;
  assign sdram_rd      = (state_q == REQ) && !we_q;
  assign sdram_wr      = (state_q == REQ) && we_q;
  assign wbs_ack       = (state_q == RESP) && !err_q;
  assign wbs_err       = (state_q == RESP) && err_q;
  assign wbs_readdata  = rdata_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed + randomized bench for sdram_wb_bridge with an in-bench transfer model.
module tb_sdram_wb_bridge;
`ifdef SDRAM_WB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 0, reset = 1;
  logic [31:0] wbs_address = 0;
  logic [15:0] wbs_writedata = 0, sdram_rd_data = 0;
  logic        wbs_strobe = 0, wbs_cycle = 0, wbs_write = 0;
  logic        sdram_op_done = 0, sdram_op_err = 0;
  logic [15:0] wbs_readdata, sdram_wr_data;
  logic [31:0] sdram_addr;
  logic        wbs_ack, wbs_err, sdram_wr, sdram_rd;

  sdram_wb_bridge #(.ADDR_W(32), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wbs_address(wbs_address), .wbs_writedata(wbs_writedata),
    .wbs_readdata(wbs_readdata), .wbs_strobe(wbs_strobe), .wbs_cycle(wbs_cycle),
    .wbs_write(wbs_write), .wbs_ack(wbs_ack), .wbs_err(wbs_err), .sdram_addr(sdram_addr),
    .sdram_wr(sdram_wr), .sdram_rd(sdram_rd), .sdram_wr_data(sdram_wr_data),
    .sdram_rd_data(sdram_rd_data), .sdram_op_done(sdram_op_done), .sdram_op_err(sdram_op_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int nrd = 0, nwr = 0, exp_rd = 0, exp_wr = 0;
  logic [15:0] exp_rdata = 0;

  always @(posedge clk) begin
    if (sdram_rd) nrd++;
    if (sdram_wr) nwr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer: REQ is cycle 0, driver completes in cycle lat, response due in cycle lat+1.
  // abort_at >= 0 drops the cycle in that cycle (must be < lat): no response expected.
  task automatic xfer(input bit we, input logic [31:0] a, input logic [15:0] wd,
                      input logic [15:0] rdv, input int lat, input bit derr, input bit both,
                      input int abort_at, input bit b2b);
    bit aborted = (abort_at >= 0);
    @(negedge clk);
    wbs_cycle = 1; wbs_strobe = 1; wbs_write = we; wbs_address = a; wbs_writedata = wd;
    @(negedge clk);
    if (we) exp_wr++; else exp_rd++;
    for (int c = 0; c <= lat + 1; c++) begin
      chk("sdram_rd", sdram_rd, (c == 0) && !we);
      chk("sdram_wr", sdram_wr, (c == 0) && we);
      chk("sdram_addr", sdram_addr, a);
      if (we) chk("sdram_wr_data", sdram_wr_data, wd);
      if (c == lat + 1) begin
        chk("ack", wbs_ack, !aborted && !derr);
        chk("err", wbs_err, !aborted && derr);
        if (!aborted && !derr && !we) exp_rdata = rdv;
        chk("readdata", wbs_readdata, exp_rdata);
      end else begin
        chk("no_ack", wbs_ack, 0);
        chk("no_err", wbs_err, 0);
      end
      sdram_op_done = (c == lat) && (!derr || both);
      sdram_op_err  = (c == lat) && derr;
      sdram_rd_data = (c == lat) ? rdv : 16'($urandom);
      if (aborted && c >= abort_at) begin wbs_cycle = 0; wbs_strobe = 0; end
      if (c == lat + 1 && !b2b) begin wbs_cycle = 0; wbs_strobe = 0; end
      if (c <= lat) @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ack", wbs_ack, 0); chk("rst_err", wbs_err, 0);
    chk("rst_rd", sdram_rd, 0); chk("rst_wr", sdram_wr, 0);
    chk("rst_addr", sdram_addr, 0); chk("rst_wdata", sdram_wr_data, 0);
    chk("rst_rdata", wbs_readdata, 0);
    @(negedge clk); reset = 0;

    // Read 0x100, done 4 cycles after the request pulse
    xfer(0, 32'h100, 16'h0, 16'hBEEF, 4, 0, 0, -1, 0);
    // Write then back-to-back read with strobe held high
    xfer(1, 32'h20, 16'h1234, 16'h0, 1, 0, 0, -1, 1);
    xfer(0, 32'h21, 16'h0, 16'h5678, 2, 0, 0, -1, 0);
    chk("b2b_rd_count", nrd, exp_rd); chk("b2b_wr_count", nwr, exp_wr);
    // Completion in the REQ cycle (minimum transfer)
    xfer(0, 32'h30, 16'h0, 16'h0A0A, 0, 0, 0, -1, 0);
    // Error and done together
    xfer(0, 32'h40, 16'h0, 16'hDEAD, 2, 1, 1, -1, 0);
    // Abort 2 cycles after sdram_rd, done 3 cycles later, then a clean read
    xfer(0, 32'h50, 16'h0, 16'h1111, 5, 0, 0, 2, 0);
    xfer(0, 32'h51, 16'h0, 16'h2222, 1, 0, 0, -1, 0);

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      int lat = $urandom_range(0, 4);
      bit de = ($urandom_range(0, 4) == 0);
      int ab = -1;
      if (lat > 0 && $urandom_range(0, 5) == 0) ab = $urandom_range(0, lat - 1);
      xfer(1'($urandom), $urandom, 16'($urandom), 16'($urandom), lat, de, 1'($urandom),
           ab, 1'($urandom));
    end
    @(negedge clk); wbs_cycle = 0; wbs_strobe = 0;
    @(negedge clk);

`ifdef SDRAM_WB_TIMEOUT_EN
    // Silent driver: error pulse 9 cycles after the request pulse
    wbs_cycle = 1; wbs_strobe = 1; wbs_write = 0; wbs_address = 32'h77;
    @(negedge clk);
    exp_rd++;
    for (int c = 0; c <= TO + 1; c++) begin
      chk("to_err", wbs_err, c == TO + 1);
      chk("to_ack", wbs_ack, 0);
      if (c == TO + 1) begin wbs_cycle = 0; wbs_strobe = 0; end
      else @(negedge clk);
    end
    xfer(0, 32'h78, 16'h0, 16'h7777, 1, 0, 0, -1, 0);
`endif

    // Reset while in WAIT, then a late done
    @(negedge clk);
    wbs_cycle = 1; wbs_strobe = 1; wbs_write = 0; wbs_address = 32'h99;
    @(negedge clk); exp_rd++;
    @(negedge clk);
    reset = 1; #1;
    chk("mid_rst_ack", wbs_ack, 0); chk("mid_rst_err", wbs_err, 0);
    chk("mid_rst_rd", sdram_rd, 0); chk("mid_rst_wr", sdram_wr, 0);
    chk("mid_rst_addr", sdram_addr, 0); chk("mid_rst_rdata", wbs_readdata, 0);
    exp_rdata = 0;
    @(negedge clk); reset = 0; wbs_cycle = 0; wbs_strobe = 0;
    @(negedge clk); sdram_op_done = 1; sdram_rd_data = 16'hCAFE;
    @(negedge clk); sdram_op_done = 0;
    for (int c = 0; c < 3; c++) begin
      chk("late_no_ack", wbs_ack, 0);
      chk("late_no_err", wbs_err, 0);
      chk("late_rdata", wbs_readdata, exp_rdata);
      @(negedge clk);
    end
    chk("rd_count", nrd, exp_rd);
    chk("wr_count", nwr, exp_wr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
